img_stream_filter: RTL and testbench

- Parametrised successor to the fixed 3x3 image pipeline: an AXI-stream pixel filter with run-time selectable kernel.
- Internal line buffers, 3x3 window, 2-stage kernel datapath and in-house output FIFO with credit-based backpressure.
- Sits between the DMA slave stream and the DMA master stream.
- Raises a one-cycle interrupt when a frame's outputs are complete.

---
 rtl/img_filter_pkg.sv | 29 ++
 rtl/img_sync_fifo.sv | 60 ++++++
 rtl/img_stream_filter.sv | 179 +++++++++++++++++
 tb/tb_img_stream_filter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/img_filter_pkg.sv
// Shared definitions for img_stream_filter: kernel mode encodings, 3x3 kernel
// weights, internal width guards and the laplacian magnitude clamp.
package img_filter_pkg;

   typedef enum logic [1:0] {
      MODE_PASS  = 2'd0,
      MODE_GAUSS = 2'd1,
      MODE_LAPL  = 2'd2,
      MODE_RSVD  = 2'd3
   } mode_e;

   // Extra bits above DATA_W: GAUSS_W = DATA_W+4, LAPL_W = DATA_W+5 (signed)
   localparam int GAUSS_GUARD = 4;
   localparam int LAPL_GUARD  = 5;
   localparam int GAUSS_ROUND = 8;
   localparam int GAUSS_SHIFT = 4;

   // Row-major 3x3 weights, index = row*3 + col
   localparam int GAUSS_K [9] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
   localparam int LAPL_K  [9] = '{-1, -1, -1, -1, 8, -1, -1, -1, -1};

   function automatic logic [31:0] clamp_abs(input logic signed [31:0] value,
                                             input logic [31:0]        maxVal);
      logic [31:0] mag;
      mag = (value < 0) ? 32'(-value) : 32'(value);
      return (mag > maxVal) ? maxVal : mag;
   endfunction

endpackage

// File: rtl/img_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count; o_popData
// reads as zero while empty so the stream output has a clean idle value.
module img_sync_fifo
   import img_filter_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH),
   localparam int CNT_W = AW + 1
)(
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_pushData,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_popData,
   output logic             o_valid,
   output logic [CNT_W-1:0] o_count
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wrPtr;
   logic [AW-1:0]    r_rdPtr;
   logic [CNT_W-1:0] r_count;
   logic             w_doPush;
   logic             w_doPop;

   assign w_doPush  = i_push && (r_count != CNT_W'(DEPTH));
   assign w_doPop   = i_pop && (r_count != '0);
   assign o_valid   = (r_count != '0);
   assign o_popData = o_valid ? r_mem[r_rdPtr] : '0;
   assign o_count   = r_count;

   always_ff @(posedge i_clk) begin
      if (w_doPush) begin
         r_mem[r_wrPtr] <= i_pushData;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_doPush) begin
            r_wrPtr <= r_wrPtr + AW'(1);
         end
         if (w_doPop) begin
            r_rdPtr <= r_rdPtr + AW'(1);
         end
         case ({w_doPush, w_doPop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/img_stream_filter.sv
// Streaming 3x3 pixel filter (pass / gaussian / laplacian) with line buffers,
// FWFT output FIFO and credit backpressure. Define IMGPROC_TLAST_EN for o_data_last.
module img_stream_filter
   import img_filter_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int IMG_W      = 512,
   parameter int IMG_H      = 512,
   parameter int FIFO_DEPTH = 16
)(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [1:0]        i_mode,
   input  logic              i_data_valid,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_data_ready,
   output logic              o_data_valid,
   output logic [DATA_W-1:0] o_data,
   input  logic              i_data_ready,
   output logic              o_intr
`ifdef IMGPROC_TLAST_EN
   ,
   output logic              o_data_last
`endif
);

   localparam int COL_W     = $clog2(IMG_W);
   localparam int ROW_W     = $clog2(IMG_H);
   localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1;
   localparam int TOTAL_OUT = (IMG_W - 2) * (IMG_H - 2);
   localparam int POP_W     = $clog2(TOTAL_OUT + 1);
   localparam int GAUSS_W   = DATA_W + GAUSS_GUARD;
   localparam int LAPL_W    = DATA_W + LAPL_GUARD;
`ifdef IMGPROC_TLAST_EN
   localparam int FIFO_W    = DATA_W + 1;
`else
   localparam int FIFO_W    = DATA_W;
`endif

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
   localparam logic [POP_W-1:0] POP_LAST = POP_W'(TOTAL_OUT - 1);
   localparam logic [31:0]      PIX_MAX  = (32'd1 << DATA_W) - 32'd1;

   logic [COL_W-1:0]          r_col;
   logic [ROW_W-1:0]          r_row;
   mode_e                     r_mode;
   logic [DATA_W-1:0]         r_lineA [IMG_W];
   logic [DATA_W-1:0]         r_lineB [IMG_W];
   logic [DATA_W-1:0]         r_win   [3][3];
   logic                      r_winValid;
   mode_e                     r_winMode;
   logic                      r_kValid;
   logic [DATA_W-1:0]         r_kData;
   logic [POP_W-1:0]          r_popCnt;
   logic                      r_intr;
`ifdef IMGPROC_TLAST_EN
   logic                      r_winLast;
   logic                      r_kLast;
`endif

   logic                      w_accept;
   logic                      w_winAt;
   logic                      w_pop;
   logic [CNT_W-1:0]          w_fifoCount;
   logic [CNT_W:0]            w_occupancy;
   logic [FIFO_W-1:0]         w_fifoIn;
   logic [FIFO_W-1:0]         w_fifoOut;
   logic [GAUSS_W-1:0]        w_gaussSum;
   logic signed [LAPL_W-1:0]  w_laplSum;
   logic [DATA_W-1:0]         w_kernel;

   // Credits: FIFO entries plus pipeline stages that will still land in it
   assign w_occupancy  = {1'b0, w_fifoCount} + (CNT_W+1)'(r_winValid) + (CNT_W+1)'(r_kValid);
   assign o_data_ready = (w_occupancy < (CNT_W+1)'(FIFO_DEPTH));
   assign w_accept     = i_data_valid && o_data_ready;
   assign w_winAt      = (r_row >= ROW_W'(2)) && (r_col >= COL_W'(2));
   assign w_pop        = o_data_valid && i_data_ready;
   assign o_intr       = r_intr;

   always_ff @(posedge i_clk) begin
      if (w_accept) begin
         r_lineB[r_col] <= r_lineA[r_col];
         r_lineA[r_col] <= i_data;
         for (int r = 0; r < 3; r++) begin
            r_win[r][0] <= r_win[r][1];
            r_win[r][1] <= r_win[r][2];
         end
         r_win[0][2] <= r_lineB[r_col];
         r_win[1][2] <= r_lineA[r_col];
         r_win[2][2] <= i_data;
      end
      r_kData <= w_kernel;
   end

   always_comb begin
      w_gaussSum = '0;
      w_laplSum  = '0;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            w_gaussSum = w_gaussSum + GAUSS_W'(r_win[r][c]) * GAUSS_W'(GAUSS_K[r*3+c]);
            w_laplSum  = w_laplSum
                       + $signed({{(LAPL_W-DATA_W){1'b0}}, r_win[r][c]})
                       * $signed(LAPL_W'(LAPL_K[r*3+c]));
         end
      end
      w_kernel = r_win[1][1];
      case (r_winMode)
         MODE_GAUSS: w_kernel = DATA_W'((w_gaussSum + GAUSS_W'(GAUSS_ROUND)) >> GAUSS_SHIFT);
         MODE_LAPL:  w_kernel = DATA_W'(clamp_abs(32'(w_laplSum), PIX_MAX));
         default:    w_kernel = r_win[1][1];
      endcase
   end

   // Window mode travels with the window so a new frame's latch never leaks back
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_col      <= '0;
         r_row      <= '0;
         r_mode     <= MODE_PASS;
         r_winValid <= 1'b0;
         r_winMode  <= MODE_PASS;
         r_kValid   <= 1'b0;
         r_popCnt   <= '0;
         r_intr     <= 1'b0;
`ifdef IMGPROC_TLAST_EN
         r_winLast  <= 1'b0;
         r_kLast    <= 1'b0;
`endif
      end else begin
         r_winValid <= w_accept && w_winAt;
         r_kValid   <= r_winValid;
`ifdef IMGPROC_TLAST_EN
         r_winLast  <= w_accept && (r_row == ROW_LAST) && (r_col == COL_LAST);
         r_kLast    <= r_winLast;
`endif
         if (w_accept) begin
            r_winMode <= r_mode;
            if ((r_row == '0) && (r_col == '0)) begin
               r_mode <= mode_e'(i_mode);
            end
            if (r_col == COL_LAST) begin
               r_col <= '0;
               r_row <= (r_row == ROW_LAST) ? '0 : r_row + ROW_W'(1);
            end else begin
               r_col <= r_col + COL_W'(1);
            end
         end
         if (w_pop) begin
            r_popCnt <= (r_popCnt == POP_LAST) ? '0 : r_popCnt + POP_W'(1);
         end
         r_intr <= w_pop && (r_popCnt == POP_LAST);
      end
   end

`ifdef IMGPROC_TLAST_EN
   assign w_fifoIn    = {r_kLast, r_kData};
   assign o_data      = w_fifoOut[DATA_W-1:0];
   assign o_data_last = w_fifoOut[DATA_W];
`else
   assign w_fifoIn    = r_kData;
   assign o_data      = w_fifoOut;
`endif

   img_sync_fifo #(
      .WIDTH (FIFO_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_push     (r_kValid),
      .i_pushData (w_fifoIn),
      .i_pop      (w_pop),
      .o_popData  (w_fifoOut),
      .o_valid    (o_data_valid),
      .o_count    (w_fifoCount)
   );

endmodule

// File: tb/tb_img_stream_filter.sv
// Scoreboard bench for img_stream_filter on an 8x4 frame with an 8-entry FIFO;
// expected pixels are hand-computed tables pushed per frame, checked by a monitor.
module tb_img_stream_filter;

   localparam int DATA_W     = 8;
   localparam int IMG_W      = 8;
   localparam int IMG_H      = 4;
   localparam int FIFO_DEPTH = 8;
   localparam int NOUT       = 12;
   localparam int KIND_CONST = 0;
   localparam int KIND_IMP   = 1;
   localparam int KIND_RAMP  = 2;

   logic              i_clk = 1'b0;
   logic              i_rst;
   logic [1:0]        i_mode;
   logic              i_data_valid;
   logic [DATA_W-1:0] i_data;
   logic              o_data_ready;
   logic              o_data_valid;
   logic [DATA_W-1:0] o_data;
   logic              i_data_ready;
   logic              o_intr;
`ifdef IMGPROC_TLAST_EN
   logic              o_data_last;
`endif

   int                checks      = 0;
   int                errors      = 0;
   int                popsInFrame = 0;
   int                intrSeen    = 0;
   bit                intrExp     = 1'b0;
   logic [7:0]        expQ [$];

   logic [7:0] expAll100 [NOUT] = '{100, 100, 100, 100, 100, 100, 100, 100, 100, 100, 100, 100};
   logic [7:0] expAll0   [NOUT] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
   logic [7:0] expLaplI  [NOUT] = '{0, 255, 255, 255, 0, 0, 0, 255, 255, 255, 0, 0};
   logic [7:0] expGaussI [NOUT] = '{0, 16, 32, 16, 0, 0, 0, 32, 64, 32, 0, 0};
   logic [7:0] expRamp   [NOUT] = '{9, 10, 11, 12, 13, 14, 17, 18, 19, 20, 21, 22};

   always #5 i_clk = ~i_clk;

   img_stream_filter #(
      .DATA_W     (DATA_W),
      .IMG_W      (IMG_W),
      .IMG_H      (IMG_H),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_mode       (i_mode),
      .i_data_valid (i_data_valid),
      .i_data       (i_data),
      .o_data_ready (o_data_ready),
      .o_data_valid (o_data_valid),
      .o_data       (o_data),
      .i_data_ready (i_data_ready),
      .o_intr       (o_intr)
`ifdef IMGPROC_TLAST_EN
      ,
      .o_data_last  (o_data_last)
`endif
   );

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic pushExpected(input logic [7:0] vals [NOUT]);
      for (int i = 0; i < NOUT; i++) begin
         expQ.push_back(vals[i]);
      end
   endtask

   function automatic logic [7:0] pixelOf(input int kind, input int r, input int c);
      if (kind == KIND_CONST) return 8'd100;
      if (kind == KIND_IMP)   return (r == 2 && c == 3) ? 8'd255 : 8'd0;
      return 8'(r * IMG_W + c);
   endfunction

   // Presents one pixel and returns #1 after the edge that accepted it
   task automatic applyStimulus(input logic [7:0] pix);
      bit acc;
      int budget;
      acc          = 1'b0;
      budget       = 0;
      i_data       = pix;
      i_data_valid = 1'b1;
      while (!acc) begin
         @(negedge i_clk);
         acc = o_data_ready;
         @(posedge i_clk);
         #1;
         budget++;
         if (!acc && budget > 500) begin
            $display("[TB] FAIL accept timeout: got no ready, expected ready within 500 cycles");
            $fatal(1, "[TB] input never accepted");
         end
      end
   endtask

   task automatic sendFrame(input int kind, input logic [1:0] modeStart, input logic [1:0] modeMid,
                            input bit stallTest, input bit timingTest, input int abortAfter);
      int winCount;
      bit stalled;
      winCount = 0;
      stalled  = stallTest;
      i_mode   = modeStart;
      if (stallTest) i_data_ready = 1'b0;
      for (int idx = 0; idx < IMG_W * IMG_H; idx++) begin
         int r;
         int c;
         r = idx / IMG_W;
         c = idx % IMG_W;
         if (abortAfter > 0 && idx == abortAfter) begin
            i_data_valid = 1'b0;
            i_rst        = 1'b1;
            expQ.delete();
            @(posedge i_clk);
            #1;
            checkOutput("abort o_data_valid", int'(o_data_valid), 0);
            checkOutput("abort o_data", int'(o_data), 0);
            checkOutput("abort o_intr", int'(o_intr), 0);
            checkOutput("abort o_data_ready", int'(o_data_ready), 1);
            i_rst = 1'b0;
            return;
         end
         if (idx == IMG_W * IMG_H / 2) i_mode = modeMid;
         if (stalled) begin
            checkOutput("stall o_data_ready", int'(o_data_ready), (winCount < FIFO_DEPTH) ? 1 : 0);
            if (winCount >= FIFO_DEPTH) begin
               i_data_valid = 1'b0;
               repeat (6) @(posedge i_clk);
               #1;
               checkOutput("stall ready held low", int'(o_data_ready), 0);
               checkOutput("stall fifo holding data", int'(o_data_valid), 1);
               i_data_ready = 1'b1;
               stalled      = 1'b0;
            end
         end
         applyStimulus(pixelOf(kind, r, c));
         if (r >= 2 && c >= 2) winCount++;
         if (timingTest && r == 2 && c == 2) begin
            i_data_valid = 1'b0;
            checkOutput("latency N+1 valid", int'(o_data_valid), 0);
            @(posedge i_clk);
            #1;
            checkOutput("latency N+2 valid", int'(o_data_valid), 0);
            @(posedge i_clk);
            #1;
            checkOutput("latency N+3 valid", int'(o_data_valid), 1);
         end
      end
   endtask

   task automatic drainOutputs();
      int budget;
      budget       = 0;
      i_data_valid = 1'b0;
      while ((expQ.size() != 0 || o_data_valid) && budget < 500) begin
         @(posedge i_clk);
         #1;
         budget++;
      end
      checkOutput("drain expected queue empty", expQ.size(), 0);
      checkOutput("drain no extra output", int'(o_data_valid), 0);
      repeat (3) @(posedge i_clk);
      #1;
   endtask

   // Monitor: samples on the falling edge, so the next rising edge pops
   always @(negedge i_clk) begin
      logic [7:0] e;
      if (i_rst) begin
         popsInFrame = 0;
         intrExp     = 1'b0;
      end else begin
         checkOutput("o_intr", int'(o_intr), int'(intrExp));
         if (o_intr) intrSeen++;
         intrExp = 1'b0;
         if (o_data_valid && i_data_ready) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected output", int'(o_data), -1);
            end else begin
               e = expQ.pop_front();
               checkOutput("o_data", int'(o_data), int'(e));
`ifdef IMGPROC_TLAST_EN
               checkOutput("o_data_last", int'(o_data_last), (popsInFrame == NOUT - 1) ? 1 : 0);
`endif
               popsInFrame++;
               if (popsInFrame == NOUT) begin
                  popsInFrame = 0;
                  intrExp     = 1'b1;
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      i_rst        = 1'b1;
      i_mode       = 2'd0;
      i_data_valid = 1'b0;
      i_data       = '0;
      i_data_ready = 1'b1;
      repeat (3) @(posedge i_clk);
      #1;
      checkOutput("reset o_data_valid", int'(o_data_valid), 0);
      checkOutput("reset o_data", int'(o_data), 0);
      checkOutput("reset o_intr", int'(o_intr), 0);
      checkOutput("reset o_data_ready", int'(o_data_ready), 1);
      i_rst = 1'b0;
      @(posedge i_clk);
      #1;

      $display("[TB] constant 100 frame, gaussian then laplacian");
      pushExpected(expAll100);
      sendFrame(KIND_CONST, 2'd1, 2'd1, 1'b0, 1'b0, 0);
      drainOutputs();
      pushExpected(expAll0);
      sendFrame(KIND_CONST, 2'd2, 2'd2, 1'b0, 1'b0, 0);
      drainOutputs();

      $display("[TB] impulse at (2,3), laplacian then gaussian");
      pushExpected(expLaplI);
      sendFrame(KIND_IMP, 2'd2, 2'd2, 1'b0, 1'b0, 0);
      drainOutputs();
      pushExpected(expGaussI);
      sendFrame(KIND_IMP, 2'd1, 2'd1, 1'b0, 1'b0, 0);
      drainOutputs();

      $display("[TB] ramp pass-through with first-output latency");
      pushExpected(expRamp);
      sendFrame(KIND_RAMP, 2'd0, 2'd0, 1'b0, 1'b1, 0);
      drainOutputs();

      $display("[TB] ramp with downstream stalled");
      pushExpected(expRamp);
      sendFrame(KIND_RAMP, 2'd0, 2'd0, 1'b1, 1'b0, 0);
      drainOutputs();

      $display("[TB] back-to-back frames with mid-frame mode toggles");
      pushExpected(expRamp);
      pushExpected(expAll0);
      sendFrame(KIND_RAMP, 2'd0, 2'd2, 1'b0, 1'b0, 0);
      sendFrame(KIND_CONST, 2'd2, 2'd1, 1'b0, 1'b0, 0);
      drainOutputs();

      $display("[TB] reset after 20 pixels, then a clean frame");
      sendFrame(KIND_RAMP, 2'd0, 2'd0, 1'b0, 1'b0, 20);
      pushExpected(expRamp);
      sendFrame(KIND_RAMP, 2'd3, 2'd1, 1'b0, 1'b0, 0);
      drainOutputs();

      checkOutput("interrupt pulse count", intrSeen, 9);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
